// File: rtl/jtopl_eg_pkg.sv
// Shared types and constants for the jtopl envelope generator engine.
package jtopl_eg_pkg;

   typedef enum logic [1:0] {
      ATTACK  = 2'd0,
      DECAY   = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } eg_phase_t;

   // Rate-high values at or above this step every frame with a larger amount.
   localparam int RATE_FAST_TH = 12;

   function automatic logic [15:0] eg_max(input int egw);
      eg_max = 16'((32'd1 << egw) - 32'd1);
   endfunction

endpackage

// File: rtl/jtopl_eg_engine_if.sv
// Slot-config / attenuation bus between the fetch logic and the envelope engine.
interface jtopl_eg_engine_if #(
   parameter int SLW = 5,
   parameter int EGW = 10
);
   logic           cen;
   logic           eg_stop;
   logic           keyon;
   logic           en_sus;
   logic [3:0]     arate;
   logic [3:0]     drate;
   logic [3:0]     rrate;
   logic [3:0]     sl;
   logic           ksr;
   logic [3:0]     keycode;
   logic [SLW-1:0] slot;
   logic           zero;
   logic [EGW-1:0] eg;
   logic [SLW-1:0] eg_slot;
   logic           pg_rst;

   modport master (
      output cen, eg_stop, keyon, en_sus, arate, drate, rrate, sl, ksr, keycode,
      input  slot, zero, eg, eg_slot, pg_rst
   );

   modport slave (
      input  cen, eg_stop, keyon, en_sus, arate, drate, rrate, sl, ksr, keycode,
      output slot, zero, eg, eg_slot, pg_rst
   );
endinterface

// File: rtl/jtopl_eg_rate.sv
// Combinational rate decoder: 4-bit rate + key scaling + frame counter -> step enable and amount.
module jtopl_eg_rate
   import jtopl_eg_pkg::*;
(
   input  logic [3:0]  i_r4,
   input  logic        i_ksr,
   input  logic [3:0]  i_keycode,
   input  logic [11:0] i_env_lo,
   output logic        o_step,
   output logic [3:0]  o_amt
);
   logic [6:0]  w_sum;
   logic [5:0]  w_eff;
   logic [3:0]  w_rh;
   logic [11:0] w_mask;

   always_comb begin
      w_sum  = {1'b0, i_r4, 2'b00} + {3'b000, (i_ksr ? i_keycode : {2'b00, i_keycode[3:2]})};
      w_eff  = (i_r4 == 4'd0) ? 6'd0 : ((w_sum > 7'd63) ? 6'd63 : w_sum[5:0]);
      w_rh   = w_eff[5:2];
      // Slow rates step only when the low (12-rh) frame-counter bits are all zero.
      w_mask = 12'hfff >> w_rh;
      o_step = 1'b0;
      o_amt  = 4'd1;
      if (w_eff != 6'd0) begin
         if (w_rh >= 4'(RATE_FAST_TH)) begin
            o_step = 1'b1;
            o_amt  = 4'd1 << (w_rh - 4'(RATE_FAST_TH));
         end else begin
            o_step = ((i_env_lo & w_mask) == 12'd0);
         end
      end
   end
endmodule

// File: rtl/jtopl_eg_engine.sv
// Time-multiplexed ADSR envelope engine: slot counter, frame counter and per-slot state words.
module jtopl_eg_engine
   import jtopl_eg_pkg::*;
#(
   parameter int SLOTS = 18,
   parameter int EGW   = 10,
   parameter int CNTW  = 15
)(
   input  logic             clk,
   input  logic             rst,
   jtopl_eg_engine_if.slave bus
);
   localparam int SLW = $clog2(SLOTS);
   localparam int SW  = EGW + 3;
   localparam logic [EGW-1:0] MAXA       = EGW'(eg_max(EGW));
   localparam logic [SW-1:0]  RESET_WORD = {RELEASE, MAXA, 1'b0};

   logic [SLW-1:0]  r_slot;
   logic [CNTW-1:0] r_env_cnt;
   logic [EGW-1:0]  r_eg;
   logic [SLW-1:0]  r_eg_slot;
   logic            r_pg_rst;

   logic [SW-1:0]   w_words [SLOTS];
   logic [SW-1:0]   w_cur;
   logic [SW-1:0]   w_wb;
   eg_phase_t       w_phase;
   eg_phase_t       w_nphase;
   logic [EGW-1:0]  w_att;
   logic [EGW-1:0]  w_natt;
   logic            w_kon;
   logic            w_edge;
   logic            w_wrap;
   logic [3:0]      w_r4;
   logic            w_step;
   logic [3:0]      w_amt;
   logic [EGW-1:0]  w_sl_lvl;
   logic [EGW:0]    w_sum_inc;
   logic [EGW-1:0]  w_inc;
   logic [EGW+3:0]  w_sub;
   logic [EGW-1:0]  w_atk;

   assign w_cur   = w_words[r_slot];
   assign w_phase = eg_phase_t'(w_cur[SW-1:SW-2]);
   assign w_att   = w_cur[EGW:1];
   assign w_kon   = w_cur[0];
   assign w_edge  = bus.keyon & ~w_kon;
   assign w_wrap  = (r_slot == SLW'(SLOTS - 1));

   assign w_r4 = (w_phase == ATTACK) ? bus.arate :
                 (w_phase == DECAY)  ? bus.drate : bus.rrate;

   jtopl_eg_rate u_rate (
      .i_r4      (w_r4),
      .i_ksr     (bus.ksr),
      .i_keycode (bus.keycode),
      .i_env_lo  (r_env_cnt[11:0]),
      .o_step    (w_step),
      .o_amt     (w_amt)
   );

   assign w_sl_lvl  = (bus.sl == 4'hf) ? MAXA : {bus.sl, {(EGW-4){1'b0}}};
   assign w_sum_inc = {1'b0, w_att} + {{(EGW-3){1'b0}}, w_amt};
   assign w_inc     = w_sum_inc[EGW] ? MAXA : w_sum_inc[EGW-1:0];
   // Attack subtrahend is computed wide so the clamp at zero is a plain compare.
   assign w_sub     = ({7'd0, w_att[EGW-1:3]} * {{EGW{1'b0}}, w_amt}) + (EGW+4)'(1);
   assign w_atk     = (w_sub >= {4'd0, w_att}) ? '0 : (w_att - w_sub[EGW-1:0]);

   always_comb begin
      w_nphase = w_phase;
      w_natt   = w_att;
      if (w_edge) begin
         if (bus.arate == 4'hf) begin
            w_natt   = '0;
            w_nphase = DECAY;
         end else begin
            w_nphase = ATTACK;
         end
      end else if (!bus.keyon && w_phase != RELEASE) begin
         w_nphase = RELEASE;
      end else begin
         case (w_phase)
            ATTACK: begin
               if (bus.arate == 4'hf || w_att == '0) begin
                  w_natt   = '0;
                  w_nphase = DECAY;
               end else if (w_step) begin
                  w_natt = w_atk;
               end
            end
            DECAY: begin
               if (w_att >= w_sl_lvl) w_nphase = SUSTAIN;
               else if (w_step)       w_natt   = w_inc;
            end
            SUSTAIN: if (!bus.en_sus && w_step) w_natt = w_inc;
            default: if (w_step) w_natt = w_inc;
         endcase
      end
   end

   // The key-on history is tracked even while frozen so unfreezing does not fake an edge.
   assign w_wb = bus.eg_stop ? {w_cur[SW-1:1], bus.keyon} : {w_nphase, w_natt, bus.keyon};

   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic [SW-1:0] r_word;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                                  r_word <= RESET_WORD;
         else if (bus.cen && r_slot == SLW'(gi))    r_word <= w_wb;
      end
      assign w_words[gi] = r_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot    <= '0;
         r_env_cnt <= '0;
         r_eg      <= MAXA;
         r_eg_slot <= '0;
         r_pg_rst  <= 1'b0;
      end else if (bus.cen) begin
         r_slot    <= w_wrap ? '0 : r_slot + 1'b1;
         if (w_wrap) r_env_cnt <= r_env_cnt + 1'b1;
         r_eg      <= bus.eg_stop ? w_att : w_natt;
         r_eg_slot <= r_slot;
         r_pg_rst  <= w_edge & ~bus.eg_stop;
      end
   end

   assign bus.slot    = r_slot;
   assign bus.zero    = (r_slot == '0);
   assign bus.eg      = r_eg;
   assign bus.eg_slot = r_eg_slot;
   assign bus.pg_rst  = r_pg_rst;
endmodule

// File: tb/tb_jtopl_eg_engine.sv
// Directed bench for jtopl_eg_engine with a per-cycle envelope model and literal spot checks.
module tb_jtopl_eg_engine;
   localparam int SLOTS = 18;
   localparam int EGW   = 10;
   localparam int SLW   = 5;
   localparam int MAXA  = 1023;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   jtopl_eg_engine_if #(.SLW(SLW), .EGW(EGW)) bus ();
   jtopl_eg_engine #(.SLOTS(SLOTS), .EGW(EGW), .CNTW(15)) dut (.clk(clk), .rst(rst), .bus(bus));

   jtopl_eg_engine_if #(.SLW(4), .EGW(12)) bus2 ();
   jtopl_eg_engine #(.SLOTS(9), .EGW(12), .CNTW(15)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int cen_mode = 0;
   bit stop_drv = 1'b0;

   int c_keyon [SLOTS];
   int c_ar    [SLOTS];
   int c_dr    [SLOTS];
   int c_rr    [SLOTS];
   int c_sl    [SLOTS];
   int c_en    [SLOTS];
   int c_ksr   [SLOTS];
   int c_kc    [SLOTS];

   // Model: phase 0=attack 1=decay 2=sustain 3=release
   int m_ph  [SLOTS];
   int m_att [SLOTS];
   int m_kon [SLOTS];
   int m_slot, m_frame, e_eg, e_slot, e_pg;

   task automatic chk(input string name, input integer got, input integer exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int mstep(input int r, input int ks, input int kc, input int frame, output int amt);
      int eff, rh;
      amt = 1;
      if (r == 0) return 0;
      eff = 4 * r + (ks != 0 ? kc : kc / 4);
      if (eff > 63) eff = 63;
      rh = eff / 4;
      if (rh >= 12) begin
         amt = 1 << (rh - 12);
         return 1;
      end
      return ((frame % (1 << (12 - rh))) == 0) ? 1 : 0;
   endfunction

   task automatic m_reset();
      for (int s = 0; s < SLOTS; s++) begin
         m_ph[s] = 3; m_att[s] = MAXA; m_kon[s] = 0;
      end
      m_slot = 0; m_frame = 0; e_eg = MAXA; e_slot = 0; e_pg = 0;
   endtask

   task automatic m_cycle();
      int s, k, ar, dr, rr, sl, en, ks, kc, stp, r, amt, st, lvl, ph, att, nedge;
      s  = m_slot;
      k  = int'(bus.keyon);   ar = int'(bus.arate); dr = int'(bus.drate);
      rr = int'(bus.rrate);   sl = int'(bus.sl);    en = int'(bus.en_sus);
      ks = int'(bus.ksr);     kc = int'(bus.keycode); stp = int'(bus.eg_stop);
      ph = m_ph[s]; att = m_att[s];
      r  = (ph == 0) ? ar : (ph == 1) ? dr : rr;
      st = mstep(r, ks, kc, m_frame, amt);
      lvl = (sl == 15) ? MAXA : sl * 64;
      nedge = (k != 0 && m_kon[s] == 0) ? 1 : 0;
      e_slot = s;
      e_pg = (nedge != 0 && stp == 0) ? 1 : 0;
      if (stp == 0) begin
         if (nedge != 0) begin
            if (ar == 15) begin att = 0; ph = 1; end
            else ph = 0;
         end else if (k == 0 && ph != 3) begin
            ph = 3;
         end else if (ph == 0) begin
            if (ar == 15 || att == 0) begin att = 0; ph = 1; end
            else if (st != 0) begin
               att = att - (att / 8) * amt - 1;
               if (att < 0) att = 0;
            end
         end else if (ph == 1) begin
            if (att >= lvl) ph = 2;
            else if (st != 0) att = (att + amt > MAXA) ? MAXA : att + amt;
         end else if (ph == 2) begin
            if (en == 0 && st != 0) att = (att + amt > MAXA) ? MAXA : att + amt;
         end else if (st != 0) begin
            att = (att + amt > MAXA) ? MAXA : att + amt;
         end
         m_ph[s] = ph; m_att[s] = att;
      end
      e_eg = m_att[s];
      m_kon[s] = k;
      if (s == SLOTS - 1) begin m_slot = 0; m_frame++; end
      else m_slot = s + 1;
   endtask

   // Model update at the active edge, DUT comparison 1 time unit later.
   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (!rst) m_reset();
         else if (bus.cen) m_cycle();
         #1;
         chk("eg",      bus.eg,      e_eg);
         chk("eg_slot", bus.eg_slot, e_slot);
         chk("pg_rst",  bus.pg_rst,  e_pg);
         chk("slot",    bus.slot,    m_slot);
         chk("zero",    bus.zero,    (m_slot == 0) ? 1 : 0);
      end
   end

   // Fetch-side driver: presents the current slot's config on the falling edge.
   initial begin
      bus.cen = 1'b1; bus.eg_stop = 1'b0; bus.keyon = 1'b0; bus.en_sus = 1'b0;
      bus.arate = 4'd0; bus.drate = 4'd0; bus.rrate = 4'd0; bus.sl = 4'd0;
      bus.ksr = 1'b0; bus.keycode = 4'd0;
      forever begin
         int s;
         @(negedge clk);
         cyc++;
         s = m_slot;
         bus.cen     = (cen_mode == 0) ? 1'b1 : cyc[0];
         bus.eg_stop = stop_drv;
         bus.keyon   = c_keyon[s][0];
         bus.arate   = c_ar[s][3:0];
         bus.drate   = c_dr[s][3:0];
         bus.rrate   = c_rr[s][3:0];
         bus.sl      = c_sl[s][3:0];
         bus.en_sus  = c_en[s][0];
         bus.ksr     = c_ksr[s][0];
         bus.keycode = c_kc[s][3:0];
      end
   end

   task automatic wait_visit(input int s);
      int n;
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (!(bus.cen === 1'b1 && int'(bus.eg_slot) == s) && n < 200);
      if (n >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL visit_timeout: slot %0d not processed within 200 cycles", s);
      end
   endtask

   initial begin
      int zc, zc2, v, prev, found;
      for (int s = 0; s < SLOTS; s++) begin
         c_keyon[s] = 0; c_ar[s] = 0; c_dr[s] = 0; c_rr[s] = 0;
         c_sl[s] = 0; c_en[s] = 0; c_ksr[s] = 0; c_kc[s] = 0;
      end
      bus2.cen = 1'b1; bus2.eg_stop = 1'b0; bus2.keyon = 1'b0; bus2.en_sus = 1'b0;
      bus2.arate = 4'd0; bus2.drate = 4'd0; bus2.rrate = 4'd0; bus2.sl = 4'd0;
      bus2.ksr = 1'b0; bus2.keycode = 4'd0;

      // Reset and one idle frame on both instances
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      zc = 0; zc2 = 0;
      for (int k = 1; k <= SLOTS; k++) begin
         @(posedge clk); #2;
         chk("rst_eg", bus.eg, MAXA);
         chk("rst_pg", bus.pg_rst, 0);
         chk("p9_slot", bus2.slot, k % 9);
         chk("p9_rst_eg", bus2.eg, 4095);
         zc  += int'(bus.zero);
         zc2 += int'(bus2.zero);
      end
      chk("zero_once_per_frame", zc, 1);
      chk("p9_zero_twice", zc2, 2);

      // 9-slot, 12-bit instance: instant attack on every slot
      bus2.keyon = 1'b1; bus2.arate = 4'd15;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #2;
         chk("p9_kon_eg", bus2.eg, 0);
         chk("p9_kon_pg", bus2.pg_rst, 1);
      end
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #2;
         chk("p9_hold_eg", bus2.eg, 0);
         chk("p9_hold_pg", bus2.pg_rst, 0);
      end

      // Instant attack on slot 3
      c_ar[3] = 15; c_sl[3] = 15; c_keyon[3] = 1;
      wait_visit(3);
      chk("inst_atk_eg", bus.eg, 0);
      chk("inst_atk_pg", bus.pg_rst, 1);
      wait_visit(3);
      chk("inst_atk2_eg", bus.eg, 0);
      chk("inst_atk2_pg", bus.pg_rst, 0);

      // Exponential attack at rate 12 on slot 7: 1023 -> 895 -> 783
      c_ar[7] = 12; c_keyon[7] = 1;
      wait_visit(7);
      chk("atk_edge_eg", bus.eg, 1023);
      chk("atk_edge_pg", bus.pg_rst, 1);
      wait_visit(7);
      chk("atk_step1", bus.eg, 895);
      wait_visit(7);
      chk("atk_step2", bus.eg, 783);

      // Decay to sustain on slot 0, plus key-scaled and clamped-rate slots
      c_ar[0] = 15; c_dr[0] = 15; c_sl[0] = 4; c_en[0] = 1; c_keyon[0] = 1;
      c_ar[10] = 15; c_dr[10] = 9; c_ksr[10] = 1; c_kc[10] = 15; c_sl[10] = 2; c_rr[10] = 2; c_keyon[10] = 1;
      c_ar[12] = 15; c_dr[12] = 3; c_kc[12] = 12; c_sl[12] = 15; c_keyon[12] = 1;
      c_ar[13] = 14; c_ksr[13] = 1; c_kc[13] = 15; c_keyon[13] = 1;
      found = 0; prev = 0;
      for (int k = 0; k < 60 && found == 0; k++) begin
         wait_visit(0);
         if (int'(bus.eg) < prev) chk("decay_monotonic", bus.eg, prev);
         prev = int'(bus.eg);
         if (bus.eg == 10'd256) found = 1;
      end
      chk("decay_reach_256", found, 1);
      for (int k = 0; k < 1000; k++) begin
         wait_visit(0);
         chk("sustain_hold", bus.eg, 256);
      end

      // Release from 256 at rate 15 saturates at all-ones
      c_keyon[0] = 0; c_rr[0] = 15;
      wait_visit(0);
      chk("rel_first", bus.eg, 256);
      wait_visit(0);
      chk("rel_step", bus.eg, 264);
      prev = 264;
      for (int k = 0; k < 110; k++) begin
         wait_visit(0);
         if (int'(bus.eg) < prev) chk("rel_monotonic", bus.eg, prev);
         prev = int'(bus.eg);
      end
      chk("rel_saturate", bus.eg, 1023);

      // Freeze mid-decay on slot 5; a key-on arriving on slot 8 while frozen
      c_ar[5] = 15; c_dr[5] = 15; c_sl[5] = 15; c_keyon[5] = 1;
      for (int k = 0; k < 20; k++) wait_visit(5);
      v = int'(bus.eg);
      chk("pre_freeze", v, 152);
      stop_drv = 1'b1;
      c_ar[8] = 15; c_keyon[8] = 1;
      for (int k = 0; k < 50; k++) begin
         wait_visit(5);
         chk("freeze_eg", bus.eg, v);
         chk("freeze_pg", bus.pg_rst, 0);
      end
      stop_drv = 1'b0;
      wait_visit(5);
      chk("unfreeze_resume", bus.eg, v + 8);
      wait_visit(8);
      chk("frozen_kon_pg", bus.pg_rst, 0);
      chk("frozen_kon_eg", bus.eg, 1023);

      // Gapped clock enable for three frames
      cen_mode = 1;
      repeat (108) @(posedge clk);
      @(negedge clk) cen_mode = 0;

      // Asynchronous mid-frame reset
      found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
         @(posedge clk); #2;
         if (bus.slot == 5'd7) found = 1;
      end
      chk("reach_slot7", found, 1);
      rst = 1'b0;
      #1;
      chk("arst_slot", bus.slot, 0);
      chk("arst_zero", bus.zero, 1);
      chk("arst_eg", bus.eg, 1023);
      chk("arst_pg", bus.pg_rst, 0);
      chk("arst_p9_eg", bus2.eg, 4095);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      wait_visit(3);
      chk("post_rst_kon_pg", bus.pg_rst, 1);
      chk("post_rst_kon_eg", bus.eg, 0);
      repeat (20) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/jtopl_eg_engine.md
Name: jtopl_eg_engine

Overview:
Parametrised, time-multiplexed ADSR envelope generator for the jtopl family. It generalises the fixed 18-slot OPL envelope stage to SLOTS slots and EGW-bit attenuation, and owns its own slot counter, frame envelope counter and per-slot state RAM. It sits between the register/slot-config fetch logic, which presents the current slot's settings, and the operator attenuation adder. Its outputs are attenuation per slot (0 = loudest, all-ones = silent) and a phase-generator reset pulse.

Parameters:
SLOTS, 18, number of time-multiplexed slots (2..64); SLW = $clog2(SLOTS) is a derived localparam
EGW, 10, attenuation width in bits (8..12)
CNTW, 15, frame envelope counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cen  in  1  slot-rate clock enable; one slot is processed per cen cycle
eg_stop  in  1  freeze all envelope updates (test hook)
keyon  in  1  key-on level for the current slot
en_sus  in  1  sustain enable for the current slot
arate  in  4  attack rate
drate  in  4  decay rate
rrate  in  4  release rate
sl  in  4  sustain level
ksr  in  1  key-scale-rate select
keycode  in  4  {block, fnum[msb]}
slot  out  SLW  index of the slot whose config must be presented this cycle
zero  out  1  high while slot==0
eg  out  EGW  attenuation of the last processed slot
eg_slot  out  SLW  slot index that eg belongs to
pg_rst  out  1  one-cen pulse on a key-on edge of eg_slot

Behaviour:
- Reset values: slot=0, zero=1, eg=all-ones, eg_slot=0, pg_rst=0, env_cnt=0. Every slot: phase=RELEASE, att=all-ones, kon_last=0. Reset asserted mid-frame aborts immediately and restarts at slot 0.
- Slot counter: advances on each cen, 0..SLOTS-1, then wraps to 0. env_cnt increments by 1 (mod 2^CNTW) on the cen where slot wraps SLOTS-1 to 0.
- Latency: inputs are sampled on the cen edge where slot==s. State write-back, eg, eg_slot=s and pg_rst are registered on that same edge and held until the next cen.
- Effective rate: r4==0 gives 0. Otherwise eff = min(63, {r4,2'b00} + (ksr ? keycode : keycode>>2)), with rh=eff[5:2].
- Step enable: rh<12 steps when env_cnt[11-rh:0]==0 with amt=1. rh>=12 steps every frame with amt = 1<<(rh-12). eff==0 never steps.
- States:
  - ATTACK: on step, att <= att - ((att>>3)*amt) - 1, clamped at 0. When att==0, go to DECAY. If arate==15, att <= 0 at once and phase=DECAY.
  - DECAY: on drate step, att <= att + amt. When att >= sl_lvl, go to SUSTAIN. sl_lvl = {sl, EGW-4 zeros}; sl==15 gives all-ones.
  - SUSTAIN: if en_sus, hold att. Otherwise advance att by amt on each rrate step.
  - RELEASE: advance att by amt on each rrate step.
- Arithmetic: every increment saturates at all-ones; there is no wrap.
- Key-on edge (keyon & ~kon_last): phase=ATTACK, pg_rst=1 for that output. Attenuation is not reset.
- keyon low in any non-RELEASE phase: go to RELEASE.
- Priority for simultaneous events: key-on edge > key-off > rate step.
- kon_last is updated on every visit to the slot, including while eg_stop is set.
- eg_stop=1: att and phase are not written, eg shows the stored att, pg_rst=0. Slot and env_cnt counters keep running.
- cen=0: no state changes at all.

Decomposition:
- Package jtopl_eg_pkg holds:
  - phase typedef: ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3
  - function eg_max(EGW)
  - constant RATE_FAST_TH=12
- Sub-module jtopl_eg_rate: purely combinational. Computes (r4, ksr, keycode, env_cnt) -> (step, amt).
- Per-slot state uses an array of SLOTS x (2+EGW+1) bits, reset asynchronously.

Test Plan:
- Reset: hold rst=0 for 5 clk, release, run 1 frame -> every eg = all-ones (1023), pg_rst=0, zero high once per SLOTS cen.
- Instant attack: slot 3, arate=15, keyon 0->1 -> eg_slot=3 shows eg=0 with pg_rst=1 on the first visit. The next visit has pg_rst=0 and phase DECAY.
- Decay to sustain: slot 0, arate=15, drate=15, sl=4, en_sus=1, keycode=0, keyon held -> eg rises to 256 (EGW=10) and stays at 256 for 1000 frames.
- Release saturation: then keyon=0 with rrate=15 -> eg climbs monotonically to 1023 and holds without wrapping.
- eg_stop: freeze during decay -> eg constant for 50 frames. Unfreeze -> decay resumes from the same value.
- Parameter sweep: SLOTS=9, EGW=12 -> slot wraps at 8, env_cnt increments every 9 cen, reset eg=4095.
